// File: rtl/regfile_wr_arbiter_if.sv
// Bundle for the requester handshakes, the clear command and the register-file write port.
// The master side drives the requests; the slave side is the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 3
);
  // valid/ready: a write transfers on a rising edge where valid and ready are both high.
  // ready is a combinational function of the arbiter state and the valids, never of the other ready.
  logic             req0_valid;
  logic [AW-1:0]    req0_addr;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [AW-1:0]    req1_addr;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             clr_req;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic             rf_src;
  logic             clr_done;
  logic [7:0]       drop_cnt;
  logic             state_dbg;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, clr_req,
    input  req0_ready, req1_ready, rf_we, rf_waddr, rf_wdata, rf_src, clr_done, drop_cnt,
    input  state_dbg
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, clr_req,
    output req0_ready, req1_ready, rf_we, rf_waddr, rf_wdata, rf_src, clr_done, drop_cnt,
    output state_dbg
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the regfile write port between two requesters,
// with a clear sequencer that zeroes x1..x7 on command.
module regfile_wr_arbiter #(
  parameter int WIDTH = 4,
  parameter int AW    = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_wr_arbiter_if.slave  bus
);
  typedef enum logic {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_ADDR  = '1;
  localparam logic [AW-1:0] FIRST_ADDR = AW'(1);

  state_t           state, state_n;
  logic             rr_ptr, rr_ptr_n;
  logic [AW-1:0]    clr_addr, clr_addr_n;
  logic             grant0, grant1;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;

  logic             rf_we_q, rf_we_n;
  logic [AW-1:0]    rf_waddr_q, rf_waddr_n;
  logic [WIDTH-1:0] rf_wdata_q, rf_wdata_n;
  logic             rf_src_q, rf_src_n;
  logic             clr_done_q, clr_done_n;
  logic [7:0]       drop_cnt_q, drop_cnt_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_ARB;
      rr_ptr     <= 1'b0;
      clr_addr   <= FIRST_ADDR;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_src_q   <= 1'b0;
      clr_done_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      clr_addr   <= clr_addr_n;
      rf_we_q    <= rf_we_n;
      rf_waddr_q <= rf_waddr_n;
      rf_wdata_q <= rf_wdata_n;
      rf_src_q   <= rf_src_n;
      clr_done_q <= clr_done_n;
      drop_cnt_q <= drop_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    clr_addr_n = clr_addr;
    grant0     = 1'b0;
    grant1     = 1'b0;
    sel_addr   = '0;
    sel_data   = '0;
    rf_we_n    = 1'b0;
    rf_waddr_n = rf_waddr_q;
    rf_wdata_n = rf_wdata_q;
    rf_src_n   = rf_src_q;
    clr_done_n = 1'b0;
    drop_cnt_n = drop_cnt_q;

    unique case (state)
      ST_ARB: begin
        if (bus.clr_req) begin
          state_n = ST_CLEAR;
        end else begin
          // rr_ptr names the requester that wins when both are valid
          grant0 = bus.req0_valid && (!bus.req1_valid || !rr_ptr);
          grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_ptr);
          sel_addr = grant1 ? bus.req1_addr : bus.req0_addr;
          sel_data = grant1 ? bus.req1_data : bus.req0_data;
          if (grant0 || grant1) begin
            rr_ptr_n = !grant1;
            if (sel_addr != '0) begin
              rf_we_n    = 1'b1;
              rf_waddr_n = sel_addr;
              rf_wdata_n = sel_data;
              rf_src_n   = grant1;
            end else if (drop_cnt_q != 8'hFF) begin
              drop_cnt_n = drop_cnt_q + 8'd1;
            end
          end
        end
      end
      ST_CLEAR: begin
        rf_we_n    = 1'b1;
        rf_waddr_n = clr_addr;
        rf_wdata_n = '0;
        rf_src_n   = 1'b0;
        if (clr_addr == LAST_ADDR) begin
          clr_addr_n = FIRST_ADDR;
          clr_done_n = 1'b1;
          state_n    = ST_ARB;
        end else begin
          clr_addr_n = clr_addr + AW'(1);
        end
      end
      default: state_n = ST_ARB;
    endcase
  end

  // No transfer may be acknowledged while reset is discarding the state update.
  assign bus.req0_ready = rst_n & grant0;
  assign bus.req1_ready = rst_n & grant1;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.rf_src     = rf_src_q;
  assign bus.clr_done   = clr_done_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.state_dbg  = (state == ST_CLEAR);
endmodule
